// File: rtl/l_modu_tick_sched.sv
// Tick scheduler: a prescaler produces a periodic TICK; four countdown channels,
// configured through a round-robin arbitrated request/ack port, pulse EXP on expiry.
module l_modu_tick_sched #(
    parameter int unsigned DIV = 50000,
    parameter int unsigned PW  = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [3:0]      cfg_req_i,
    input  logic [4*PW-1:0] cfg_period_i,
    input  logic [3:0]      cfg_mode_i,
    output logic [3:0]      cfg_ack_o,
    output logic            tick_o,
    output logic [3:0]      exp_o,
    output logic [3:0]      busy_o
);
    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} ch_state_e;

    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tick_q, tick_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [NCH-1:0] ack_q;
    logic [NCH-1:0] exp_q, exp_d;
    logic [NCH-1:0] mode_q, mode_d;
    ch_state_e      state_q [NCH];
    ch_state_e      state_d [NCH];
    logic [PW-1:0]  rem_q   [NCH];
    logic [PW-1:0]  rem_d   [NCH];
    logic [PW-1:0]  per_q   [NCH];
    logic [PW-1:0]  per_d   [NCH];
    logic [NCH-1:0] grant_c;
    logic           grant_vld_c;
    logic [1:0]     grant_idx_c;

    // Prescaler: wraps at DIV-1 and flags the wrap for a registered TICK.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (en_i) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Round-robin search from ptr_q; a requester being acked this cycle is skipped.
    always_comb begin
        logic [NCH-1:0] elig;
        logic [1:0]     idx;
        elig        = cfg_req_i & ~ack_q;
        idx         = '0;
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        grant_c     = '0;
        ptr_d       = ptr_q;
        for (int k = 0; k < NCH; k++) begin
            idx = ptr_q + 2'(k);
            if (!grant_vld_c && elig[idx]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = idx;
            end
        end
        if (grant_vld_c) begin
            grant_c = 4'b0001 << grant_idx_c;
            ptr_d   = grant_idx_c + 2'd1;
        end
    end

    // Channel next state; a granted write takes priority over a coincident tick.
    always_comb begin
        exp_d  = '0;
        mode_d = mode_q;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            rem_d[i]   = rem_q[i];
            per_d[i]   = per_q[i];
            if (grant_c[i]) begin
                per_d[i]   = cfg_period_i[i*PW +: PW];
                rem_d[i]   = cfg_period_i[i*PW +: PW];
                mode_d[i]  = cfg_mode_i[i];
                state_d[i] = (cfg_period_i[i*PW +: PW] != '0) ? ST_RUN : ST_IDLE;
            end else if (tick_q && (state_q[i] == ST_RUN)) begin
                if (rem_q[i] > PW'(1)) begin
                    rem_d[i] = rem_q[i] - PW'(1);
                end else begin
                    exp_d[i] = 1'b1;
                    if (mode_q[i]) begin
                        rem_d[i] = per_q[i];
                    end else begin
                        rem_d[i]   = '0;
                        state_d[i] = ST_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            ptr_q  <= '0;
            ack_q  <= '0;
            exp_q  <= '0;
            mode_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                rem_q[i]   <= '0;
                per_q[i]   <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            ptr_q  <= ptr_d;
            ack_q  <= grant_c;
            exp_q  <= exp_d;
            mode_q <= mode_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
                per_q[i]   <= per_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            busy_o[i] = (state_q[i] == ST_RUN);
        end
    end

    assign cfg_ack_o = ack_q;
    assign tick_o    = tick_q;
    assign exp_o     = exp_q;

endmodule

// File: tb/tb_l_modu_tick_sched.sv
// Directed bench for l_modu_tick_sched (DIV=4, PW=8) with ACK/EXP scoreboards.
module tb_l_modu_tick_sched;
    localparam int unsigned DIV = 4;
    localparam int unsigned PW  = 8;

    logic            clk;
    logic            rst;
    logic            en;
    logic [3:0]      req;
    logic [4*PW-1:0] period;
    logic [3:0]      mode;
    logic [3:0]      ack;
    logic            tick;
    logic [3:0]      expo;
    logic [3:0]      busy;

    l_modu_tick_sched #(.DIV(DIV), .PW(PW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .cfg_req_i    (req),
        .cfg_period_i (period),
        .cfg_mode_i   (mode),
        .cfg_ack_o    (ack),
        .tick_o       (tick),
        .exp_o        (expo),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         tno;
        logic [3:0] mask;
        logic [3:0] clr;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
        logic [3:0] set;
        logic [3:0] clr;
    } ack_t;

    exp_t       exp_sb[$];
    ack_t       ack_sb[$];
    int         checks;
    int         failures;
    int         cyc;
    int         pcnt;
    int         ntick;
    logic       tick_m;
    logic [3:0] busy_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    // Advance one clock, update the reference prescaler and scoreboards, compare outputs.
    task automatic step();
        logic       prev_tick;
        int         prev_no;
        logic [3:0] e_exp;
        logic [3:0] e_ack;
        prev_tick = tick_m;
        prev_no   = ntick;
        @(posedge clk);
        #1;
        cyc++;
        e_exp = '0;
        e_ack = '0;
        if (rst) begin
            pcnt   = 0;
            tick_m = 1'b0;
            busy_m = '0;
        end else begin
            if (en) begin
                if (pcnt == int'(DIV) - 1) begin
                    pcnt   = 0;
                    tick_m = 1'b1;
                    ntick++;
                end else begin
                    pcnt++;
                    tick_m = 1'b0;
                end
            end else begin
                tick_m = 1'b0;
            end
            if (prev_tick && exp_sb.size() > 0 && exp_sb[0].tno == prev_no) begin
                e_exp  = exp_sb[0].mask;
                busy_m = busy_m & ~exp_sb[0].clr;
                void'(exp_sb.pop_front());
            end
            if (ack_sb.size() > 0 && ack_sb[0].cyc == cyc) begin
                e_ack  = ack_sb[0].mask;
                busy_m = (busy_m & ~ack_sb[0].clr) | ack_sb[0].set;
                void'(ack_sb.pop_front());
            end
        end
        chk("tick", 32'(tick), 32'(tick_m));
        chk("ack",  32'(ack),  32'(e_ack));
        chk("exp",  32'(expo), 32'(e_exp));
        chk("busy", 32'(busy), 32'(busy_m));
    endtask

    // Single-requester write; returns the tick number preceding the first counted tick.
    task automatic write_ch(input int ch, input int per, input logic md, output int base);
        ack_t       a;
        logic [3:0] m;
        m      = 4'b0001 << ch;
        a.cyc  = cyc + 1;
        a.mask = m;
        a.set  = (per != 0) ? m : 4'b0000;
        a.clr  = (per != 0) ? 4'b0000 : m;
        ack_sb.push_back(a);
        req[ch]              = 1'b1;
        period[ch*PW +: PW]  = PW'(per);
        mode[ch]             = md;
        step();
        req[ch] = 1'b0;
        base    = tick_m ? ntick - 1 : ntick;
    endtask

    task automatic exp_push(input int tno, input logic [3:0] m, input logic [3:0] c);
        exp_t e;
        e.tno  = tno;
        e.mask = m;
        e.clr  = c;
        exp_sb.push_back(e);
    endtask

    task automatic run_to_tick(input int tno);
        for (int k = 0; k < 200; k++) begin
            if (tick_m && ntick == tno) break;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   b;
        int   b2;
        ack_t a;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        pcnt     = 0;
        ntick    = 0;
        tick_m   = 1'b0;
        busy_m   = '0;
        rst      = 1'b1;
        en       = 1'b0;
        req      = '0;
        period   = '0;
        mode     = '0;
        repeat (2) step();
        rst = 1'b0;

        // Prescaler free run
        en = 1'b1;
        repeat (20) step();

        // All four request at once, each holding until its own ack
        for (int k = 0; k < 4; k++) begin
            a.cyc  = cyc + 1 + k;
            a.mask = 4'b0001 << k;
            a.set  = 4'b0000;
            a.clr  = 4'b0001 << k;
            ack_sb.push_back(a);
        end
        period = '0;
        req    = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k > 0) req[k-1] = 1'b0;
        end
        req[3] = 1'b0;
        step();

        // EN low freezes the prescaler but config writes still complete
        en = 1'b0;
        write_ch(3, 0, 1'b1, b);
        repeat (5) step();
        en = 1'b1;
        repeat (6) step();

        // One-shot period 3 on channel 0
        write_ch(0, 3, 1'b0, b);
        exp_push(b + 3, 4'b0001, 4'b0001);
        repeat (24) step();

        // Periodic period 2 on channel 1 for five periods, then stop
        write_ch(1, 2, 1'b1, b);
        for (int k = 1; k <= 5; k++) exp_push(b + 2*k, 4'b0010, 4'b0000);
        run_to_tick(b + 10);
        step();
        write_ch(1, 0, 1'b0, b2);
        repeat (20) step();

        // Periodic period 1 expires on every tick
        write_ch(2, 1, 1'b1, b);
        for (int k = 1; k <= 3; k++) exp_push(b + k, 4'b0100, 4'b0000);
        run_to_tick(b + 3);
        step();
        write_ch(2, 0, 1'b0, b2);
        repeat (8) step();

        // Rewrite channel 2 in the tick cycle where it would expire
        write_ch(2, 2, 1'b0, b);
        run_to_tick(b + 2);
        write_ch(2, 3, 1'b0, b2);
        exp_push(b2 + 3, 4'b0100, 4'b0100);
        repeat (20) step();

        // Reset with channel 0 at remaining=1 and requester 3 pending
        write_ch(0, 2, 1'b0, b);
        run_to_tick(b + 1);
        step();
        req[3]            = 1'b1;
        period[3*PW +: PW] = PW'(4);
        mode[3]           = 1'b0;
        rst               = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        write_ch(3, 4, 1'b0, b);
        exp_push(b + 4, 4'b1000, 4'b1000);
        repeat (24) step();

        chk("exp_sb_drained", 32'(exp_sb.size()), 32'd0);
        chk("ack_sb_drained", 32'(ack_sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l_modu_tick_sched.md
L_MODU_TICK_SCHED -- requirements
Module: l_modu_tick_sched

Interface
REQ-001 Parameter DIV, default 50000, SHALL set system-clock cycles per tick (50 MHz -> 1 ms); legal range 2..2^20.
REQ-002 Parameter PW, default 16, SHALL set channel period width in ticks.
REQ-003 CLK  in  1  SHALL be the single system clock; all logic on its rising edge.
REQ-004 RST  in  1  SHALL be the synchronous, active-high reset.
REQ-005 EN  in  1  SHALL enable the tick prescaler; 0 freezes it.
REQ-006 CFG_REQ  in  4  SHALL carry per-requester config requests; requester i owns channel i.
REQ-007 CFG_PERIOD  in  4*PW  SHALL carry requester i's period on bits [i*PW +: PW].
REQ-008 CFG_MODE  in  4  SHALL select per requester: 1 periodic, 0 one-shot.
REQ-009 CFG_ACK  out  4  SHALL be a one-hot, one-cycle grant acknowledge.
REQ-010 TICK  out  1  SHALL be a one-cycle pulse per prescaler wrap.
REQ-011 EXP  out  4  SHALL be one-cycle per-channel expiry pulses.
REQ-012 BUSY  out  4  SHALL be high while channel i is in RUN.

Function
REQ-013 Prescaler SHALL count 0..DIV-1 while EN=1, wrapping to 0; it SHALL hold its value while EN=0.
REQ-014 TICK SHALL be registered, high for exactly the cycle after the count goes DIV-1 -> 0; no TICK while EN=0.
REQ-015 Arbiter SHALL grant at most one requester per cycle, round-robin: search starts at pointer P (reset 0); after a grant to i, P = (i+1) mod 4.
REQ-016 Requester i SHALL be ineligible in any cycle where CFG_ACK[i]=1 (no double grant while REQ drops).
REQ-017 Grant decided in cycle N SHALL raise CFG_ACK[i] in cycle N+1 and update channel i at that same edge; requester holds REQ, period, mode stable until ACK.
REQ-018 Each channel SHALL have states IDLE and RUN, a PW-bit remaining counter, a PW-bit stored period and a mode bit.
REQ-019 Granted write with period != 0: remaining = period, store period/mode, state -> RUN (restart if already RUN).
REQ-020 Granted write with period = 0: state -> IDLE, no EXP generated (stop command).
REQ-021 On TICK in RUN: remaining > 1 -> decrement; remaining = 1 -> EXP[i] pulse next cycle, then periodic reloads stored period and stays RUN, one-shot goes IDLE.
REQ-022 Period 1 periodic SHALL expire on every TICK; period 2^PW-1 SHALL not overflow (no wrap through 0).
REQ-023 Config write and TICK coinciding on same channel: write wins, that tick ignored for that channel, no EXP.
REQ-024 Channels SHALL be independent; several EXP bits may pulse in the same cycle.
REQ-025 EN=0 SHALL freeze all RUN countdowns but SHALL NOT block config writes.

Reset
REQ-026 RST=1 at a clock edge SHALL clear prescaler, P, all channels to IDLE with remaining/period/mode = 0, and drive TICK, EXP, BUSY, CFG_ACK to 0 from the next cycle.
REQ-027 RST mid-countdown or mid-handshake SHALL abort it; no EXP or ACK SHALL appear for pre-reset requests until they are re-arbitrated after RST falls.

Verification (DIV=4, PW=8)
REQ-028 EN=1 for 20 cycles -> TICK pulses every 4 cycles, exactly 1 cycle wide; EN=0 for 6 cycles -> no TICK, phase resumes.
REQ-029 Req0 period 3 one-shot -> ACK0 1 cycle, BUSY0=1, EXP0 after 3rd TICK, BUSY0=0, no further EXP0.
REQ-030 Req1 period 2 periodic -> EXP1 on every 2nd TICK for 5 periods; then req1 period 0 -> BUSY1=0, no EXP1.
REQ-031 CFG_REQ=4'b1111 held until own ACK -> ACKs in order 0,1,2,3 on consecutive-granted cycles, never two bits high, no repeat grants.
REQ-032 Write to channel 2 in TICK cycle while remaining=1 -> no EXP2, remaining = new period.
REQ-033 RST pulse with ch0 at remaining=1 and req3 pending -> all outputs 0, no EXP0, ACK3 only after re-grant.
